// File: rtl/usb_phy_pkg.sv
// Shared types and constants for the USB receive datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_phy_pkg;

    // Receive framing state: waiting for SYNC, assembling words, or dropping a bad packet.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX      = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_t;

    // USB inserts a zero after six consecutive ones.
    localparam int STUFF_LIMIT_DEFAULT = 6;

endpackage

// File: rtl/usb_bit_unstuff.sv
// Bit unstuffer: counts consecutive ones, drops the stuffed zero, flags a stuffed one.
// Latency: combinational pass-through of the bit; the ones counter updates on the clock.
// Backpressure: none; every qualified bit is consumed in the cycle it arrives.
module usb_bit_unstuff
    import usb_phy_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_bit_vld,
    input  logic i_bit_dat,
    output logic o_bit_vld,
    output logic o_bit_dat,
    output logic o_stuff_err
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [OW-1:0] LIMIT = OW'(STUFF_LIMIT);

    logic [OW-1:0] ones_cnt;
    logic          at_limit;

    // The bit right after a full run of ones is the stuffed bit and never reaches the word.
    assign at_limit    = (ones_cnt == LIMIT);
    assign o_bit_vld   = i_bit_vld && !at_limit;
    assign o_bit_dat   = i_bit_dat;
    assign o_stuff_err = i_bit_vld && at_limit && i_bit_dat;

    // Run length of ones, continuous across word boundaries; the stuffed bit always restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ones_cnt <= '0;
        end else if (i_clr) begin
            ones_cnt <= '0;
        end else if (i_bit_vld) begin
            if (at_limit || !i_bit_dat) begin
                ones_cnt <= '0;
            end else begin
                ones_cnt <= ones_cnt + OW'(1);
            end
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// USB receive deserializer: unstuffs line bits and packs them into DATA_WIDTH words.
// Latency: one cycle from the last bit of a word (or from EOP) to o_valid / pulse outputs.
// Backpressure: o_valid held until i_ready; a word completing while one is held is dropped with o_err_overrun.
module rx_deserializer
    import usb_phy_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_data,
    input  logic                    i_valid,
    input  logic                    i_sync_pattern,
    input  logic                    i_eop,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_keep,
    output logic                    o_valid,
    output logic                    o_eop,
    output logic                    o_err_stuff,
    output logic                    o_err_align,
    output logic                    o_err_overrun
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DATA_WIDTH / 2);

    rx_state_t             state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] flush_dat;
    logic                  ub_vld;
    logic                  ub_dat;
    logic                  stuff_err;
    logic                  word_done;
    logic                  out_free;

    usb_bit_unstuff #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_unstuff (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_sync_pattern),
        .i_bit_vld   (i_valid && (state == ST_RX) && !i_sync_pattern),
        .i_bit_dat   (i_data),
        .o_bit_vld   (ub_vld),
        .o_bit_dat   (ub_dat),
        .o_stuff_err (stuff_err)
    );

    assign out_free  = !o_valid || i_ready;
    assign word_done = ub_vld && (bit_cnt == CNT_LAST);

    // Shift direction sets bit order; the eight bits of a half word sit at the shift-in end.
    always_comb begin
        if (LSB_FIRST) begin
            shift_nxt = {ub_dat, shift_q[DATA_WIDTH-1:1]};
            flush_dat = DATA_WIDTH'(shift_q[DATA_WIDTH-1 -: 8]);
        end else begin
            shift_nxt = {shift_q[DATA_WIDTH-2:0], ub_dat};
            flush_dat = DATA_WIDTH'(shift_q[7:0]);
        end
    end

    // Framing FSM, word assembly, output register and one-cycle status pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            o_data        <= '0;
            o_keep        <= '0;
            o_valid       <= 1'b0;
            o_eop         <= 1'b0;
            o_err_stuff   <= 1'b0;
            o_err_align   <= 1'b0;
            o_err_overrun <= 1'b0;
        end else begin
            o_eop         <= 1'b0;
            o_err_stuff   <= 1'b0;
            o_err_align   <= 1'b0;
            o_err_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (i_sync_pattern) begin
                // SYNC restarts framing from any state and outranks a coincident bit or EOP.
                state   <= ST_RX;
                bit_cnt <= '0;
                shift_q <= '0;
            end else begin
                case (state)
                    ST_RX: begin
                        if (stuff_err) begin
                            o_err_stuff <= 1'b1;
                            state       <= ST_DISCARD;
                            bit_cnt     <= '0;
                            shift_q     <= '0;
                        end else if (ub_vld) begin
                            if (word_done) begin
                                bit_cnt <= '0;
                                shift_q <= '0;
                                if (out_free) begin
                                    o_data  <= shift_nxt;
                                    o_keep  <= '1;
                                    o_valid <= 1'b1;
                                end else begin
                                    o_err_overrun <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                                shift_q <= shift_nxt;
                            end
                        end else if (i_eop) begin
                            o_eop   <= 1'b1;
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            shift_q <= '0;
                            if (bit_cnt != '0) begin
                                if ((DATA_WIDTH == 16) && (bit_cnt == CNT_HALF)) begin
                                    // A whole trailing byte in a 16-bit word goes out alone.
                                    if (out_free) begin
                                        o_data  <= flush_dat;
                                        o_keep  <= KW'(1);
                                        o_valid <= 1'b1;
                                    end else begin
                                        o_err_overrun <= 1'b1;
                                    end
                                end else begin
                                    o_err_align <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (i_eop) begin
                            o_eop <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        // Idle: line activity is meaningless until SYNC.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_deserializer.sv
// Bench for rx_deserializer: 8-bit and 16-bit instances driven by the same line.
// Latency: checks sample one cycle after the stimulus edge.
// Backpressure: exercised in the directed hold/overrun step; random packets run with i_ready high.
module tb_rx_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, din, vld, sync, eop, rdy;

    logic [7:0]  d8_data;
    logic        d8_keep, d8_valid, d8_eop, d8_es, d8_ea, d8_eo;
    logic [15:0] d16_data;
    logic [1:0]  d16_keep;
    logic        d16_valid, d16_eop, d16_es, d16_ea, d16_eo;

    rx_deserializer #(.DATA_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vld),
        .i_sync_pattern(sync), .i_eop(eop), .i_ready(rdy),
        .o_data(d8_data), .o_keep(d8_keep), .o_valid(d8_valid), .o_eop(d8_eop),
        .o_err_stuff(d8_es), .o_err_align(d8_ea), .o_err_overrun(d8_eo)
    );

    rx_deserializer #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vld),
        .i_sync_pattern(sync), .i_eop(eop), .i_ready(rdy),
        .o_data(d16_data), .o_keep(d16_keep), .o_valid(d16_valid), .o_eop(d16_eop),
        .o_err_stuff(d16_es), .o_err_align(d16_ea), .o_err_overrun(d16_eo)
    );

    int checks = 0;
    int errors = 0;

    typedef logic [31:0] tok_t;
    typedef tok_t tq_t[$];

    localparam int TK_WORD  = 1;
    localparam int TK_STUFF = 2;
    localparam int TK_ALIGN = 3;
    localparam int TK_OVR   = 4;
    localparam int TK_EOP   = 5;

    tq_t act8, act16, exp8, exp16;
    bit  pay_q[$];

    function automatic tok_t mk(int t, logic [1:0] k, logic [15:0] d);
        logic [7:0] t8;
        t8 = t[7:0];
        return {t8, 6'd0, k, d};
    endfunction

    // Observed event stream per instance: accepted words, then pulses in a fixed order per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (d8_valid && rdy) act8.push_back(mk(TK_WORD, {1'b0, d8_keep}, {8'h00, d8_data}));
            if (d8_es)  act8.push_back(mk(TK_STUFF, 2'b00, 16'h0));
            if (d8_ea)  act8.push_back(mk(TK_ALIGN, 2'b00, 16'h0));
            if (d8_eo)  act8.push_back(mk(TK_OVR,   2'b00, 16'h0));
            if (d8_eop) act8.push_back(mk(TK_EOP,   2'b00, 16'h0));
            if (d16_valid && rdy) act16.push_back(mk(TK_WORD, d16_keep, d16_data));
            if (d16_es)  act16.push_back(mk(TK_STUFF, 2'b00, 16'h0));
            if (d16_ea)  act16.push_back(mk(TK_ALIGN, 2'b00, 16'h0));
            if (d16_eo)  act16.push_back(mk(TK_OVR,   2'b00, 16'h0));
            if (d16_eop) act16.push_back(mk(TK_EOP,   2'b00, 16'h0));
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(logic v, logic d, logic s, logic e);
        @(posedge clk);
        #1;
        vld = v; din = d; sync = s; eop = e;
    endtask

    task automatic idle(int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(logic [31:0] v, int n);
        for (int i = 0; i < n; i++) tick(1'b1, v[i], 1'b0, 1'b0);
    endtask

    task automatic set_pay(logic [31:0] v, int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(v[i]);
    endtask

    // Reference: the first nbits payload bits (unstuffed, in line order) cut into words,
    // then the packet ending as stuff error, aligned end, half-word flush or misaligned end.
    function automatic tq_t model(int w, int nbits, bit serr);
        tq_t         q;
        logic [15:0] word;
        int          rem;
        for (int k = 0; k + w <= nbits; k += w) begin
            word = '0;
            for (int j = 0; j < w; j++) word[j] = pay_q[k + j];
            q.push_back(mk(TK_WORD, (w == 16) ? 2'b11 : 2'b01, word));
        end
        rem = nbits % w;
        if (serr) begin
            q.push_back(mk(TK_STUFF, 2'b00, 16'h0));
        end else if (rem == 8) begin
            word = '0;
            for (int j = 0; j < 8; j++) word[j] = pay_q[nbits - 8 + j];
            q.push_back(mk(TK_WORD, 2'b01, word));
        end else if (rem != 0) begin
            q.push_back(mk(TK_ALIGN, 2'b00, 16'h0));
        end
        q.push_back(mk(TK_EOP, 2'b00, 16'h0));
        return q;
    endfunction

    task automatic cmp(string tag);
        chk({tag, " count8"}, act8.size(), exp8.size());
        for (int i = 0; i < exp8.size() && i < act8.size(); i++)
            chk($sformatf("%s ev8[%0d]", tag, i), act8[i], exp8[i]);
        chk({tag, " count16"}, act16.size(), exp16.size());
        for (int i = 0; i < exp16.size() && i < act16.size(); i++)
            chk($sformatf("%s ev16[%0d]", tag, i), act16[i], exp16[i]);
        act8.delete();
        act16.delete();
    endtask

    // Transmitter side: SYNC, payload with a zero inserted after every six ones, EOP.
    // Optionally replaces the first inserted zero with a one.
    task automatic send_packet(input bit want_err, output int nb, output bit injected);
        int run;
        run = 0;
        injected = 1'b0;
        nb = pay_q.size();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < pay_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            tick(1'b1, pay_q[i], 1'b0, 1'b0);
            run = pay_q[i] ? run + 1 : 0;
            if (run == 6) begin
                if (want_err) begin
                    tick(1'b1, 1'b1, 1'b0, 1'b0);
                    injected = 1'b1;
                    nb = i + 1;
                    break;
                end
                tick(1'b1, 1'b0, 1'b0, 1'b0);
                run = 0;
            end
        end
        if (injected) send_bits($urandom, $urandom_range(0, 10));
        idle($urandom_range(0, 2));
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
    endtask

    initial begin
        int  nb;
        bit  inj;
        rst = 1'b0; din = 1'b0; vld = 1'b0; sync = 1'b0; eop = 1'b0; rdy = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset outputs w8", {d8_data, d8_keep, d8_valid, d8_eop, d8_es, d8_ea, d8_eo}, 32'h0);
        chk("reset outputs w16", {d16_data, d16_keep, d16_valid, d16_eop, d16_es, d16_ea, d16_eo}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        act8.delete(); act16.delete();

        // Basic LSB-first byte: 1,0,1,1,0,0,0,0 -> 0x0D, one cycle after the eighth bit.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'h0D, 8);
        chk("0D not early", d8_valid, 1'b0);
        idle(1);
        chk("0D word", {d8_valid, d8_keep, d8_data}, {1'b1, 1'b1, 8'h0D});
        idle(1);
        chk("0D valid one cycle", d8_valid, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("0D flush w16", {d16_valid, d16_eop, d16_keep, d16_data}, {1'b1, 1'b1, 2'b01, 16'h000D});
        chk("0D eop w8", {d8_eop, d8_ea}, 2'b10);
        idle(2);
        set_pay(32'h0D, 8);
        exp8 = model(8, 8, 1'b0); exp16 = model(16, 8, 1'b0);
        cmp("pkt 0D");

        // 0xFF sent as six ones, stuffed zero, two ones.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'h1BF, 9);
        idle(1);
        chk("FF word", {d8_valid, d8_data}, {1'b1, 8'hFF});
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        set_pay(32'hFF, 8);
        exp8 = model(8, 8, 1'b0); exp16 = model(16, 8, 1'b0);
        cmp("pkt FF");

        // Stuffed one: error pulse, rest of packet ignored until EOP.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'h7F, 7);
        idle(1);
        chk("stuff err pulse", {d8_es, d16_es}, 2'b11);
        idle(1);
        chk("stuff err one cycle", {d8_es, d16_es}, 2'b00);
        send_bits(32'hFF, 8);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        set_pay(32'h3F, 6);
        exp8 = model(8, 6, 1'b1); exp16 = model(16, 6, 1'b1);
        cmp("pkt stuff1");

        // 24 bits: 0xA55A then 0x3C, ending on a half word for the 16-bit instance.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'hA55A, 16);
        send_bits(32'h3C, 8);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("3C flush w16", {d16_valid, d16_eop, d16_keep, d16_data}, {1'b1, 1'b1, 2'b01, 16'h003C});
        idle(2);
        set_pay(32'h3CA55A, 24);
        exp8 = model(8, 24, 1'b0); exp16 = model(16, 24, 1'b0);
        cmp("pkt A55A3C");

        // Backpressure: first byte held, second byte lost.
        rdy = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'h11, 8);
        send_bits(32'h22, 8);
        idle(1);
        chk("ovr w8", {d8_valid, d8_data, d8_eo}, {1'b1, 8'h11, 1'b1});
        chk("ovr w16", {d16_valid, d16_data, d16_eo}, {1'b1, 16'h2211, 1'b0});
        idle(3);
        chk("hold w8", {d8_valid, d8_keep, d8_data, d8_eo}, {1'b1, 1'b1, 8'h11, 1'b0});
        @(posedge clk);
        #1 rdy = 1'b1;
        idle(1);
        chk("accept clears valid", {d8_valid, d16_valid}, 2'b00);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        exp8.delete(); exp16.delete();
        exp8.push_back(mk(TK_OVR, 2'b00, 16'h0));
        exp8.push_back(mk(TK_WORD, 2'b01, 16'h0011));
        exp8.push_back(mk(TK_EOP, 2'b00, 16'h0));
        exp16.push_back(mk(TK_WORD, 2'b11, 16'h2211));
        exp16.push_back(mk(TK_EOP, 2'b00, 16'h0));
        cmp("pkt overrun");

        // Five bits then EOP: misaligned end.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'h16, 5);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("align w8", {d8_ea, d8_eop, d8_valid}, 3'b110);
        chk("align w16", {d16_ea, d16_eop, d16_valid}, 3'b110);
        idle(2);
        set_pay(32'h16, 5);
        exp8 = model(8, 5, 1'b0); exp16 = model(16, 5, 1'b0);
        cmp("pkt align");

        // A bit coincident with SYNC is not part of the packet.
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(32'h0D, 8);
        idle(1);
        chk("sync+valid", {d8_valid, d8_data}, {1'b1, 8'h0D});
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        set_pay(32'h0D, 8);
        exp8 = model(8, 8, 1'b0); exp16 = model(16, 8, 1'b0);
        cmp("pkt sync+valid");

        // Asynchronous reset mid-byte with a word held.
        rdy = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(32'hC3, 8);
        send_bits(32'h5, 3);
        #3;
        rst = 1'b1; vld = 1'b0; din = 1'b0;
        #1;
        chk("async rst w8", {d8_data, d8_keep, d8_valid, d8_eop, d8_es, d8_ea, d8_eo}, 32'h0);
        chk("async rst w16", {d16_data, d16_keep, d16_valid, d16_eop, d16_es, d16_ea, d16_eo}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; rdy = 1'b1;
        act8.delete(); act16.delete();
        idle(3);
        // Back in idle: bits and EOP without SYNC produce nothing.
        send_bits(32'hFF, 8);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        exp8.delete(); exp16.delete();
        cmp("post reset idle");

        // Random packets, stuffing-heavy payloads, some with a corrupted stuffed bit.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(0, 40);
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back($urandom_range(0, 3) != 0);
            send_packet($urandom_range(0, 3) == 0, nb, inj);
            exp8 = model(8, nb, inj);
            exp16 = model(16, nb, inj);
            cmp($sformatf("rnd%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
